// File: rtl/sop_bist_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | sop_bist_pkg : state encoding and width helpers, BIST checker |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package sop_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int VEC_W          = 5 * DEF_DATA_WIDTH;
  localparam int SUM_W          = 2 * DEF_DATA_WIDTH + 2;
  localparam int ERR_W          = 16;

  function automatic int vec_width(input int dw);
    return 5 * dw;
  endfunction

  function automatic int sum_width(input int dw);
    return 2 * dw + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sop_bist_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------+
// | sop_bist_checker_if : stimulus/result bus to sum_of_products  |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
interface sop_bist_checker_if #(
  parameter int DATA_WIDTH = 4
);
  import sop_bist_pkg::*;

  logic [DATA_WIDTH-1:0]            data_in;
  logic [DATA_WIDTH-1:0]            coef11;
  logic [DATA_WIDTH-1:0]            coef12;
  logic [DATA_WIDTH-1:0]            coef21;
  logic [DATA_WIDTH-1:0]            coef22;
  logic [sum_width(DATA_WIDTH)-1:0] final_sum;

  modport master (
    output data_in, coef11, coef12, coef21, coef22,
    input  final_sum
  );

  modport slave (
    input  data_in, coef11, coef12, coef21, coef22,
    output final_sum
  );

endinterface
`default_nettype wire

// File: rtl/sop_golden_model.sv
`default_nettype none
// +--------------------------------------------------------------+
// | sop_golden_model : expected final_sum with latency-matched    |
// | valid/index pipe.  Rev 1.0                                    |
// +--------------------------------------------------------------+
module sop_golden_model
  import sop_bist_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int DUT_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      vec_valid,
  input  logic [5*DATA_WIDTH-1:0]   vec,
  output logic [2*DATA_WIDTH+1:0]   exp_sum,
  output logic                      exp_valid,
  output logic [5*DATA_WIDTH-1:0]   exp_idx
);

  localparam int VW = vec_width(DATA_WIDTH);
  localparam int SW = sum_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]  d0, c11, c12, c21, c22;
  logic [DATA_WIDTH-1:0]  d1, d2, d3;
  logic [SW-1:0]          sum0;
  logic [SW-1:0]          sum_pipe [DUT_LATENCY];
  logic [VW-1:0]          idx_pipe [DUT_LATENCY];
  logic [DUT_LATENCY-1:0] vld_pipe;

  assign {d0, c11, c12, c21, c22} = vec;

  assign sum0 = (SW'(d0) * SW'(c11) + SW'(d1) * SW'(c12))
              + (SW'(d2) * SW'(c21) + SW'(d3) * SW'(c22));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      vld_pipe <= '0;
      for (int i = 0; i < DUT_LATENCY; i++) begin
        sum_pipe[i] <= '0;
        idx_pipe[i] <= '0;
      end
    end else if (clear) begin
      // a new run must not see data or valids left over from the last one
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      vld_pipe <= '0;
    end else begin
      d1          <= d0;
      d2          <= d1;
      d3          <= d2;
      sum_pipe[0] <= sum0;
      idx_pipe[0] <= vec;
      vld_pipe[0] <= vec_valid;
      for (int i = 1; i < DUT_LATENCY; i++) begin
        sum_pipe[i] <= sum_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign exp_sum   = sum_pipe[DUT_LATENCY-1];
  assign exp_idx   = idx_pipe[DUT_LATENCY-1];
  assign exp_valid = vld_pipe[DUT_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/sop_bist_checker.sv
`default_nettype none
// +--------------------------------------------------------------+
// | sop_bist_checker : exhaustive BIST driver/checker for         |
// | sum_of_products. Option macro: SOP_BIST_ERR_INJECT_EN. Rev 1.0 |
// +--------------------------------------------------------------+
module sop_bist_checker
  import sop_bist_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int DUT_LATENCY = 1,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
`ifdef SOP_BIST_ERR_INJECT_EN
  input  logic                    inject,
`endif
  sop_bist_checker_if.master      bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [5*DATA_WIDTH-1:0] first_err
);

  localparam int VW    = vec_width(DATA_WIDTH);
  localparam int SW    = sum_width(DATA_WIDTH);
  localparam int DRN_W = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;

  localparam logic [VW-1:0]    IDX_MAX   = '1;
  localparam logic [VW-1:0]    IDX_ONE   = VW'(1);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [DRN_W-1:0] DRN_ONE   = DRN_W'(1);
  localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(DUT_LATENCY - 1);

  state_t           state_q, state_d;
  logic [VW-1:0]    idx_q;
  logic [DRN_W-1:0] drain_q;
  logic [ERR_W-1:0] err_q;
  logic [VW-1:0]    first_q;
  logic [SW-1:0]    exp_sum, sum_cmp;
  logic [VW-1:0]    exp_idx;
  logic             exp_valid;
  logic             start_ok, mismatch;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);

  sop_golden_model #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DUT_LATENCY (DUT_LATENCY)
  ) u_golden (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .vec_valid (state_q == RUN),
    .vec       (idx_q),
    .exp_sum   (exp_sum),
    .exp_valid (exp_valid),
    .exp_idx   (exp_idx)
  );

`ifdef SOP_BIST_ERR_INJECT_EN
  // inject tags the vector being driven and travels with it to the compare
  logic [DUT_LATENCY-1:0] inj_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_q <= '0;
    end else if (start_ok) begin
      inj_q <= '0;
    end else begin
      inj_q[0] <= inject && (state_q == RUN);
      for (int i = 1; i < DUT_LATENCY; i++) begin
        inj_q[i] <= inj_q[i-1];
      end
    end
  end

  assign sum_cmp = bus.final_sum ^ SW'(inj_q[DUT_LATENCY-1]);
`else
  assign sum_cmp = bus.final_sum;
`endif

  // X/Z on final_sum is a failure, hence the 4-state compare
  assign mismatch = (state_q == RUN || state_q == DRAIN) && exp_valid
                    && (sum_cmp !== exp_sum);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (STOP_ON_ERR && mismatch)  state_d = DONE;
               else if (idx_q == IDX_MAX)    state_d = DRAIN;
      DRAIN:   if ((STOP_ON_ERR && mismatch) || drain_q == DRN_LAST) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      // idx doubles as the stimulus register, so it rests at 0 outside RUN
      idx_q   <= (state_q == RUN && state_d == RUN) ? idx_q + IDX_ONE : '0;
      drain_q <= (state_q == DRAIN) ? drain_q + DRN_ONE : '0;
      if (start_ok) begin
        err_q   <= '0;
        first_q <= '0;
      end else if (mismatch) begin
        if (err_q != '1) err_q   <= err_q + ERR_ONE;
        if (err_q == '0) first_q <= exp_idx;
      end
    end
  end

  assign {bus.data_in, bus.coef11, bus.coef12, bus.coef21, bus.coef22} = idx_q;

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign first_err = first_q;

endmodule
`default_nettype wire

// File: tb/tb_sop_bist_checker.sv
`default_nettype none
// Bench for sop_bist_checker: two checkers (latency 1/stop-on-error, latency 2/count-all)
// each facing an emulated sum_of_products with programmable bit0 faults.
module tb_sop_bist_checker;

  localparam int DW    = 2;
  localparam int NV    = 1024;
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
`ifdef SOP_BIST_ERR_INJECT_EN
  logic inject = 1'b0;
`endif
  always #5 clk = ~clk;

  sop_bist_checker_if #(.DATA_WIDTH(DW)) bus_a ();
  sop_bist_checker_if #(.DATA_WIDTH(DW)) bus_b ();

  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] err_a, err_b;
  logic [9:0]  first_a, first_b;

  sop_bist_checker #(.DATA_WIDTH(DW), .DUT_LATENCY(1), .STOP_ON_ERR(1'b1)) u_chk_a (
    .clk(clk), .rst(rst), .start(start_a),
`ifdef SOP_BIST_ERR_INJECT_EN
    .inject(inject),
`endif
    .bus(bus_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err(first_a));

  sop_bist_checker #(.DATA_WIDTH(DW), .DUT_LATENCY(2), .STOP_ON_ERR(1'b0)) u_chk_b (
    .clk(clk), .rst(rst), .start(start_b),
`ifdef SOP_BIST_ERR_INJECT_EN
    .inject(inject),
`endif
    .bus(bus_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err(first_b));

  int checks = 0;
  int errors = 0;

  // ---------------- emulated sum_of_products DUTs ----------------
  int fmode_a = 0, flo_a = 0, fhi_a = 0;   // mode 0 none, 1 force bit0=1, 2 invert bit0
  int fmode_b = 0, flo_b = 0, fhi_b = 0;

  logic [9:0] stim_a, stim_b;
  assign stim_a = {bus_a.data_in, bus_a.coef11, bus_a.coef12, bus_a.coef21, bus_a.coef22};
  assign stim_b = {bus_b.data_in, bus_b.coef11, bus_b.coef12, bus_b.coef21, bus_b.coef22};

  function automatic logic [5:0] sop(input logic [1:0] d0, c11, d1, c12, d2, c21, d3, c22);
    int s;
    s = int'(d0) * int'(c11) + int'(d1) * int'(c12) + int'(d2) * int'(c21) + int'(d3) * int'(c22);
    return 6'(s);
  endfunction

  function automatic logic [5:0] faulty(input logic [5:0] s, input int idx, mode, lo, hi);
    logic [5:0] r;
    r = s;
    if (idx >= lo && idx <= hi) begin
      if (mode == 1)      r[0] = 1'b1;
      else if (mode == 2) r[0] = ~r[0];
    end
    return r;
  endfunction

  logic [1:0] ha1, ha2, ha3, hb1, hb2, hb3;
  logic [5:0] pb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ha1 <= '0; ha2 <= '0; ha3 <= '0;
      bus_a.final_sum <= '0;
    end else begin
      ha1 <= bus_a.data_in; ha2 <= ha1; ha3 <= ha2;
      bus_a.final_sum <= faulty(sop(bus_a.data_in, bus_a.coef11, ha1, bus_a.coef12,
                                    ha2, bus_a.coef21, ha3, bus_a.coef22),
                                int'(stim_a), fmode_a, flo_a, fhi_a);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hb1 <= '0; hb2 <= '0; hb3 <= '0; pb <= '0;
      bus_b.final_sum <= '0;
    end else begin
      hb1 <= bus_b.data_in; hb2 <= hb1; hb3 <= hb2;
      pb <= faulty(sop(bus_b.data_in, bus_b.coef11, hb1, bus_b.coef12,
                       hb2, bus_b.coef21, hb3, bus_b.coef22),
                   int'(stim_b), fmode_b, flo_b, fhi_b);
      bus_b.final_sum <= pb;
    end
  end

  // ---------------- reference model: run outcome from the vector list ----------------
  function automatic int ref_data(input int j);
    return (j < 0) ? 0 : ((j >> 8) & 3);
  endfunction

  function automatic int ref_exp(input int i);
    return ref_data(i) * ((i >> 6) & 3) + ref_data(i - 1) * ((i >> 4) & 3)
         + ref_data(i - 2) * ((i >> 2) & 3) + ref_data(i - 3) * (i & 3);
  endfunction

  task automatic ref_errors(input int mode, lo, hi, output int cnt, output int first);
    bit bad;
    cnt = 0; first = 0;
    for (int i = 0; i < NV; i++) begin
      bad = (i >= lo) && (i <= hi) && (mode == 2 || (mode == 1 && (ref_exp(i) % 2) == 0));
      if (bad) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endtask

  // start both checkers and follow them until both report done (bounded)
  task automatic run_both(input int restart_at, input bit inj0,
                          output int cyc_a, output int cyc_b,
                          output logic [9:0] mid_a, output int rise_a);
    int   cyc;
    bit   seen_a, seen_b;
    logic prev_a;
    cyc = 0; seen_a = 0; seen_b = 0; prev_a = 1'b1;
    cyc_a = 0; cyc_b = 0; mid_a = '0; rise_a = 0;
    @(negedge clk);
    start_a = 1'b1; start_b = 1'b1;
    while (cyc < BOUND && !(seen_a && seen_b)) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      start_a = (cyc == restart_at);
      start_b = (cyc == restart_at);
`ifdef SOP_BIST_ERR_INJECT_EN
      inject = inj0 && (cyc == 1);
`endif
      if (cyc == 301) mid_a = stim_a;
      if (done_a && !prev_a) rise_a++;
      prev_a = done_a;
      if (done_a && !seen_a) begin seen_a = 1; cyc_a = cyc; end
      if (done_b && !seen_b) begin seen_b = 1; cyc_b = cyc; end
    end
    start_a = 1'b0; start_b = 1'b0;
`ifdef SOP_BIST_ERR_INJECT_EN
    inject = 1'b0;
`else
    if (inj0) $display("note: inject ignored in this build");
`endif
    repeat (6) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a: got %b want 0", done_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL reset_pass_a: got %b want 0", pass_a); end
    checks++; if (err_a !== 16'd0) begin errors++; $display("FAIL reset_err_a: got %0d want 0", err_a); end
    checks++; if (first_a !== 10'd0) begin errors++; $display("FAIL reset_first_a: got %0d want 0", first_a); end
    checks++; if (stim_a !== 10'd0) begin errors++; $display("FAIL reset_stim_a: got %h want 0", stim_a); end
    checks++; if ({busy_b, done_b, pass_b, err_b, first_b, stim_b} !== 39'd0) begin
      errors++; $display("FAIL reset_outs_b: got %h want 0", {busy_b, done_b, pass_b, err_b, first_b, stim_b}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if ({busy_a, done_a, busy_b, done_b} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b want 0000", {busy_a, done_a, busy_b, done_b}); end
  endtask

  task automatic test_clean_run();
    int ca, cb, ra;
    logic [9:0] mid;
    fmode_a = 0; fmode_b = 0;
    run_both(0, 1'b0, ca, cb, mid, ra);
    checks++; if (ca != 1026) begin errors++; $display("FAIL clean_latency_a: got %0d want 1026", ca); end
    checks++; if (cb != 1027) begin errors++; $display("FAIL clean_latency_b: got %0d want 1027", cb); end
    checks++; if (mid !== 10'd300) begin errors++; $display("FAIL stim_mapping: got %0d want 300", mid); end
    checks++; if (pass_a !== 1'b1 || err_a !== 16'd0 || first_a !== 10'd0) begin
      errors++; $display("FAIL clean_result_a: got pass=%b err=%0d first=%0d want 1/0/0", pass_a, err_a, first_a); end
    checks++; if (pass_b !== 1'b1 || err_b !== 16'd0 || first_b !== 10'd0) begin
      errors++; $display("FAIL clean_result_b: got pass=%b err=%0d first=%0d want 1/0/0", pass_b, err_b, first_b); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b1) begin
      errors++; $display("FAIL done_held_a: got busy=%b done=%b want 0/1", busy_a, done_a); end
  endtask

  task automatic test_fault(input string tag, input int mode, input int lo, input int hi);
    int ca, cb, ra, cnt, first;
    logic [9:0] mid;
    fmode_a = mode; flo_a = lo; fhi_a = hi;
    fmode_b = mode; flo_b = lo; fhi_b = hi;
    ref_errors(mode, lo, hi, cnt, first);
    run_both(0, 1'b0, ca, cb, mid, ra);
    fmode_a = 0; fmode_b = 0;
    checks++; if (ca == 0 || cb == 0) begin errors++; $display("FAIL %s_done: got cyc_a=%0d cyc_b=%0d want nonzero", tag, ca, cb); end
    checks++; if (err_a !== 16'((cnt > 0) ? 1 : 0) || pass_a !== (cnt == 0)) begin
      errors++; $display("FAIL %s_stop_a: got err=%0d pass=%b want err=%0d pass=%b", tag, err_a, pass_a, (cnt > 0) ? 1 : 0, cnt == 0); end
    checks++; if (first_a !== 10'(first)) begin errors++; $display("FAIL %s_first_a: got %0d want %0d", tag, first_a, first); end
    checks++; if (err_b !== 16'(cnt) || pass_b !== (cnt == 0)) begin
      errors++; $display("FAIL %s_count_b: got err=%0d pass=%b want err=%0d pass=%b", tag, err_b, pass_b, cnt, cnt == 0); end
    checks++; if (first_b !== 10'(first)) begin errors++; $display("FAIL %s_first_b: got %0d want %0d", tag, first_b, first); end
  endtask

  task automatic test_random_faults();
    int lo, hi, mode;
    for (int k = 0; k < 3; k++) begin
      lo   = int'($urandom_range(1023, 0));
      hi   = int'($urandom_range(1023, lo));
      mode = int'($urandom_range(2, 1));
      test_fault("rand", mode, lo, hi);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, ca, cb, ra;
    logic [9:0] mid;
    fmode_b = 2; flo_b = 10; fhi_b = 1023;
    cyc = 0;
    @(negedge clk);
    start_a = 1'b1; start_b = 1'b1;
    while (cyc < 501) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++; if ({busy_a, done_a, pass_a, err_a, first_a, stim_a} !== 39'd0) begin
      errors++; $display("FAIL midrst_outs_a: got %h want 0", {busy_a, done_a, pass_a, err_a, first_a, stim_a}); end
    checks++; if ({busy_b, done_b, pass_b, err_b, first_b, stim_b} !== 39'd0) begin
      errors++; $display("FAIL midrst_outs_b: got %h want 0", {busy_b, done_b, pass_b, err_b, first_b, stim_b}); end
    repeat (2) @(negedge clk);
    rst = 1'b0; fmode_b = 0;
    repeat (4) @(negedge clk);
    run_both(0, 1'b0, ca, cb, mid, ra);
    checks++; if (pass_a !== 1'b1 || pass_b !== 1'b1 || ca != 1026 || cb != 1027) begin
      errors++; $display("FAIL midrst_rerun: got pass=%b%b cyc=%0d/%0d want 11 1026/1027", pass_a, pass_b, ca, cb); end
  endtask

  task automatic test_start_during_run();
    int ca, cb, ra;
    logic [9:0] mid;
    run_both(101, 1'b0, ca, cb, mid, ra);
    checks++; if (ca != 1026 || cb != 1027) begin
      errors++; $display("FAIL restart_latency: got %0d/%0d want 1026/1027", ca, cb); end
    checks++; if (ra != 1) begin errors++; $display("FAIL restart_done_rises: got %0d want 1", ra); end
    checks++; if (pass_a !== 1'b1 || pass_b !== 1'b1) begin
      errors++; $display("FAIL restart_pass: got %b%b want 11", pass_a, pass_b); end
  endtask

`ifdef SOP_BIST_ERR_INJECT_EN
  task automatic test_inject();
    int ca, cb, ra;
    logic [9:0] mid;
    run_both(0, 1'b1, ca, cb, mid, ra);
    checks++; if (err_a !== 16'd1 || first_a !== 10'd0 || pass_a !== 1'b0) begin
      errors++; $display("FAIL inject_a: got err=%0d first=%0d pass=%b want 1/0/0", err_a, first_a, pass_a); end
    checks++; if (err_b !== 16'd1 || first_b !== 10'd0 || pass_b !== 1'b0) begin
      errors++; $display("FAIL inject_b: got err=%0d first=%0d pass=%b want 1/0/0", err_b, first_b, pass_b); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_run();
    test_fault("idx37", 1, 37, 1023);
    test_fault("last", 2, 1023, 1023);
    test_random_faults();
    test_reset_mid_run();
    test_start_during_run();
`ifdef SOP_BIST_ERR_INJECT_EN
    test_inject();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
